// File: rtl/instr_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package instr_cache_pkg;

  typedef enum logic {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } ic_state_e;

  localparam int unsigned IC_WORD_BITS     = 32;
  localparam int unsigned IC_BYTE_OFF_BITS = 2;

  function automatic int unsigned ic_word_sel_bits(int unsigned line_bits);
    return $clog2(line_bits / IC_WORD_BITS);
  endfunction

  function automatic int unsigned ic_offset_bits(int unsigned line_bits);
    return IC_BYTE_OFF_BITS + ic_word_sel_bits(line_bits);
  endfunction

  function automatic int unsigned ic_index_bits(int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned ic_tag_bits(int unsigned addr_bits, int unsigned lines,
                                              int unsigned line_bits);
    return addr_bits - ic_index_bits(lines) - ic_offset_bits(line_bits);
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side lookup and memory-side refill signals of the instruction cache.
interface instr_cache_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned LINE_BITS = 128
);
  import instr_cache_pkg::*;

  logic [ADDR_BITS-1:0]    address;
  logic [IC_WORD_BITS-1:0] data;
  logic                    stall;
  logic                    mem_read;
  logic [ADDR_BITS-1:0]    mem_address;
  logic                    mem_ready;
  logic [LINE_BITS-1:0]    mem_data;

  modport slave (
    input  address, mem_ready, mem_data,
    output data, stall, mem_read, mem_address
  );

  modport master (
    output address, mem_ready, mem_data,
    input  data, stall, mem_read, mem_address
  );
endinterface

// File: rtl/instr_cache_array.sv
// Valid/tag/line storage: one combinational read port, one synchronous write port.
module icache_array
  import instr_cache_pkg::*;
#(
  parameter int unsigned LINES     = 4,
  parameter int unsigned TAG_BITS  = 26,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [ic_index_bits(LINES)-1:0]   rd_index,
  output logic                              rd_valid,
  output logic [TAG_BITS-1:0]               rd_tag,
  output logic [LINE_BITS-1:0]              rd_line,
  input  logic                              wr_en,
  input  logic [ic_index_bits(LINES)-1:0]   wr_index,
  input  logic [TAG_BITS-1:0]               wr_tag,
  input  logic [LINE_BITS-1:0]              wr_line
);

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_BITS-1:0] line_q [LINES];

  // Only the valid bits are reset; tag and data are don't-care until valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      line_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = line_q[rd_index];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, stall and
// line refill over a request/ready handshake on a miss.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int unsigned LINES     = 4,
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned ADDR_BITS = 32
) (
  input  logic          clock,
  input  logic          reset,
  instr_cache_if.slave  bus
);

  localparam int unsigned WORDS         = LINE_BITS / IC_WORD_BITS;
  localparam int unsigned WORD_SEL_BITS = ic_word_sel_bits(LINE_BITS);
  localparam int unsigned OFFSET_BITS   = ic_offset_bits(LINE_BITS);
  localparam int unsigned INDEX_BITS    = ic_index_bits(LINES);
  localparam int unsigned TAG_BITS      = ic_tag_bits(ADDR_BITS, LINES, LINE_BITS);

  ic_state_e state_q, state_d;
  logic [ADDR_BITS-1:0] line_addr_q, line_addr_d;
  logic                 mem_read_q, mem_read_d;

  logic [INDEX_BITS-1:0]    index_c;
  logic [TAG_BITS-1:0]      tag_c;
  logic [WORD_SEL_BITS-1:0] word_sel_c;
  logic                     rd_valid;
  logic [TAG_BITS-1:0]      rd_tag;
  logic [LINE_BITS-1:0]     rd_line;
  logic [WORDS-1:0][IC_WORD_BITS-1:0] rd_words;
  logic                     hit_c;
  logic                     wr_en_c;
  logic [IC_WORD_BITS-1:0]  data_c;
  logic                     stall_c;
  logic                     unused_byte_off;

  assign index_c         = bus.address[OFFSET_BITS +: INDEX_BITS];
  assign tag_c           = bus.address[ADDR_BITS-1 -: TAG_BITS];
  assign word_sel_c      = bus.address[IC_BYTE_OFF_BITS +: WORD_SEL_BITS];
  assign unused_byte_off = ^bus.address[IC_BYTE_OFF_BITS-1:0];

  icache_array #(
    .LINES     (LINES),
    .TAG_BITS  (TAG_BITS),
    .LINE_BITS (LINE_BITS)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .rd_index (index_c),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en_c),
    .wr_index (line_addr_q[OFFSET_BITS +: INDEX_BITS]),
    .wr_tag   (line_addr_q[ADDR_BITS-1 -: TAG_BITS]),
    .wr_line  (bus.mem_data)
  );

  assign rd_words = rd_line;
  assign hit_c    = rd_valid && (rd_tag == tag_c);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IC_IDLE;
      line_addr_q <= '0;
      mem_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      mem_read_q  <= mem_read_d;
    end
  end

  // The refill always completes against the latched line address, regardless of address.
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    mem_read_d  = 1'b0;
    wr_en_c     = 1'b0;
    data_c      = '0;
    stall_c     = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (hit_c) begin
          data_c = rd_words[word_sel_c];
        end else begin
          stall_c     = 1'b1;
          state_d     = IC_REFILL;
          mem_read_d  = 1'b1;
          line_addr_d = {tag_c, index_c, {OFFSET_BITS{1'b0}}};
        end
      end
      IC_REFILL: begin
        stall_c    = 1'b1;
        mem_read_d = 1'b1;
        if (bus.mem_ready) begin
          wr_en_c    = 1'b1;
          state_d    = IC_IDLE;
          mem_read_d = 1'b0;
        end
      end
      default: state_d = IC_IDLE;
    endcase
    if (reset) begin
      data_c  = '0;
      stall_c = 1'b0;
      wr_en_c = 1'b0;
    end
  end

  assign bus.data        = data_c;
  assign bus.stall       = stall_c;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = line_addr_q;

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: vector table with a scoreboard queue,
// plus hand sequences for reset during refill and address change during refill.
module tb_instr_cache;

  typedef struct {
    logic [31:0] addr;
    int unsigned ready_at;     // 0: mem_ready held high; k: pulse in k-th refill cycle
    int unsigned stall_cycles;
    int unsigned rd_cycles;
    logic [31:0] mem_addr;
    logic [31:0] data;
  } vec_t;

  logic clock = 1'b0;
  logic reset;

  instr_cache_if #(.ADDR_BITS(32), .LINE_BITS(128)) bus ();

  instr_cache #(.LINES(4), .LINE_BITS(128), .ADDR_BITS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  vec_t        sb_q [$];
  vec_t        vecs [11];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Main-memory contents: line 0 is the fixed pattern, others derive from the address.
  function automatic logic [31:0] gen_word(logic [31:0] line_addr, int unsigned w);
    logic [3:0][31:0] l0;
    l0 = 128'h44444444_33333333_22222222_11111111;
    if (line_addr == 32'h0) return l0[2'(w)];
    return (line_addr + 32'(4 * w)) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [127:0] gen_line(logic [31:0] line_addr);
    logic [3:0][31:0] l;
    for (int w = 0; w < 4; w++) l[2'(w)] = gen_word(line_addr, 32'(w));
    return l;
  endfunction

  function automatic logic [31:0] exp_word(logic [31:0] addr);
    return gen_word({addr[31:4], 4'b0}, 32'(addr[3:2]));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step(input logic [31:0] addr, input logic rdy, input logic rst);
    @(negedge clock);
    reset         = rst;
    bus.address   = addr;
    bus.mem_ready = rdy;
    bus.mem_data  = gen_line(bus.mem_address);
    #1;
  endtask

  task automatic fetch(input vec_t v);
    int unsigned stall_cnt = 0;
    int unsigned rd_cnt    = 0;
    logic [31:0] seen_addr = '0;
    bit          done      = 1'b0;
    vec_t        e;
    sb_q.push_back(v);
    for (int c = 0; c < 64 && !done; c++) begin
      step(v.addr, (v.ready_at == 0) || (32'(c) == v.ready_at), 1'b0);
      if (bus.stall) begin
        stall_cnt++;
        if (bus.mem_read) begin
          rd_cnt++;
          seen_addr = bus.mem_address;
        end
      end else begin
        done = 1'b1;
        e = sb_q.pop_front();
        chk($sformatf("data@%08h", e.addr), bus.data, e.data);
        chk($sformatf("stall_cycles@%08h", e.addr), stall_cnt, 32'(e.stall_cycles));
        chk($sformatf("mem_read_cycles@%08h", e.addr), rd_cnt, 32'(e.rd_cycles));
        chk($sformatf("mem_read_low@%08h", e.addr), 32'(bus.mem_read), 32'h0);
        if (e.rd_cycles > 0)
          chk($sformatf("mem_address@%08h", e.addr), seen_addr, e.mem_addr);
      end
    end
    if (!done) begin
      e = sb_q.pop_front();
      n_total++;
      $display("FAIL timeout@%08h: stall still high after 64 cycles, expected release", e.addr);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.address   = 32'h4;
    bus.mem_ready = 1'b0;
    bus.mem_data  = '0;

    step(32'h4, 1'b0, 1'b1);
    step(32'h4, 1'b0, 1'b1);
    chk("reset_stall", 32'(bus.stall), 32'h0);
    chk("reset_data", bus.data, 32'h0);
    chk("reset_mem_read", 32'(bus.mem_read), 32'h0);
    chk("reset_mem_address", bus.mem_address, 32'h0);

    vecs[0]  = '{32'h004, 3, 4, 3, 32'h000, 32'h22222222};
    vecs[1]  = '{32'h000, 1, 0, 0, 32'h000, 32'h11111111};
    vecs[2]  = '{32'h008, 1, 0, 0, 32'h000, 32'h33333333};
    vecs[3]  = '{32'h00C, 1, 0, 0, 32'h000, 32'h44444444};
    vecs[4]  = '{32'h040, 2, 3, 2, 32'h040, exp_word(32'h040)};
    vecs[5]  = '{32'h000, 1, 2, 1, 32'h000, 32'h11111111};
    vecs[6]  = '{32'h014, 4, 5, 4, 32'h010, exp_word(32'h014)};
    vecs[7]  = '{32'h01C, 1, 0, 0, 32'h000, exp_word(32'h01C)};
    vecs[8]  = '{32'h104, 2, 3, 2, 32'h100, exp_word(32'h104)};
    vecs[9]  = '{32'h230, 0, 2, 1, 32'h230, exp_word(32'h230)};
    vecs[10] = '{32'h2A8, 0, 2, 1, 32'h2A0, exp_word(32'h2A8)};
    for (int i = 0; i < 11; i++) fetch(vecs[i]);

    // Reset lands in the second refill cycle together with mem_ready.
    fetch('{32'h008, 1, 2, 1, 32'h000, 32'h33333333});
    fetch('{32'h008, 1, 0, 0, 32'h000, 32'h33333333});
    step(32'h54, 1'b0, 1'b0);
    chk("rmr_miss_stall", 32'(bus.stall), 32'h1);
    step(32'h54, 1'b0, 1'b0);
    chk("rmr_mem_read_high", 32'(bus.mem_read), 32'h1);
    step(32'h54, 1'b1, 1'b1);
    chk("rmr_stall_in_reset", 32'(bus.stall), 32'h0);
    chk("rmr_data_in_reset", bus.data, 32'h0);
    step(32'h54, 1'b0, 1'b1);
    chk("rmr_mem_read_dropped", 32'(bus.mem_read), 32'h0);
    chk("rmr_mem_address_cleared", bus.mem_address, 32'h0);
    fetch('{32'h008, 1, 2, 1, 32'h000, 32'h33333333});
    fetch('{32'h054, 1, 2, 1, 32'h050, exp_word(32'h054)});

    // Address moves to another line while a refill is outstanding.
    step(32'h10, 1'b0, 1'b0);
    chk("chg_miss_stall", 32'(bus.stall), 32'h1);
    step(32'h24, 1'b0, 1'b0);
    chk("chg_mem_read", 32'(bus.mem_read), 32'h1);
    chk("chg_mem_address_c1", bus.mem_address, 32'h10);
    chk("chg_stall_c1", 32'(bus.stall), 32'h1);
    step(32'h24, 1'b0, 1'b0);
    chk("chg_mem_address_c2", bus.mem_address, 32'h10);
    step(32'h24, 1'b1, 1'b0);
    chk("chg_mem_address_c3", bus.mem_address, 32'h10);
    chk("chg_data_c3", bus.data, 32'h0);
    fetch('{32'h024, 1, 2, 1, 32'h020, exp_word(32'h024)});
    fetch('{32'h010, 1, 0, 0, 32'h000, exp_word(32'h010)});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
